// File: rtl/lsu_store_buffer_if.sv
// Store-buffer bus bundle: EXU store request channel, data-memory write
// channel, load hazard probe and status.
//   master : core/memory side (drives st_*, ld_addr, mem_wr_ready)
//   slave  : store buffer     (drives st_ready, st_misalign, mem_wr_*,
//                              ld_conflict, sb_empty)
interface lsu_store_buffer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [1:0]        st_size;
  logic [31:0]       st_data;
  logic              st_misalign;

  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_wr_strb;

  logic [ADDR_W-1:0] ld_addr;
  logic              ld_conflict;
  logic              sb_empty;

  modport master (
    output st_valid, st_addr, st_size, st_data, mem_wr_ready, ld_addr,
    input  st_ready, st_misalign, mem_wr_valid, mem_wr_addr, mem_wr_data,
           mem_wr_strb, ld_conflict, sb_empty
  );

  modport slave (
    input  st_valid, st_addr, st_size, st_data, mem_wr_ready, ld_addr,
    output st_ready, st_misalign, mem_wr_valid, mem_wr_addr, mem_wr_data,
           mem_wr_strb, ld_conflict, sb_empty
  );
endinterface

// File: rtl/lsu_store_buffer.sv
// In-order store buffer between the EXU and the data-memory write port.
// Formats byte/half/word stores into word-aligned, lane-replicated writes with
// byte strobes, queues up to DEPTH of them and drains over valid/ready.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   sb_if  : lsu_store_buffer_if.slave (store channel, memory write channel,
//            load hazard probe, empty status)
module lsu_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  lsu_store_buffer_if.slave  sb_if
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WA_W  = ADDR_W - 2;

  // Entry storage (word address only; byte offset is carried by the strobe)
  logic [WA_W-1:0]  r_waddr [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [3:0]       r_strb  [DEPTH];
  logic             r_vld   [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_nonempty;
  logic             r_misalign;

  logic [31:0]      w_fmt_data;
  logic [3:0]       w_fmt_strb;
  logic             w_misaligned;
  logic             w_accept;
  logic             w_enq;
  logic             w_deq;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_ld_hit;

  // Store formatting: replicate data across lanes, build byte strobe, flag misalignment
  always_comb begin
    w_fmt_data   = '0;
    w_fmt_strb   = '0;
    w_misaligned = 1'b1;
    case (sb_if.st_size)
      2'd0: begin
        w_fmt_data   = {4{sb_if.st_data[7:0]}};
        w_fmt_strb   = 4'b0001 << sb_if.st_addr[1:0];
        w_misaligned = 1'b0;
      end
      2'd1: begin
        w_fmt_data   = {2{sb_if.st_data[15:0]}};
        w_fmt_strb   = sb_if.st_addr[1] ? 4'b1100 : 4'b0011;
        w_misaligned = sb_if.st_addr[0];
      end
      2'd2: begin
        w_fmt_data   = sb_if.st_data;
        w_fmt_strb   = 4'b1111;
        w_misaligned = (sb_if.st_addr[1:0] != 2'b00);
      end
      default: begin
        w_misaligned = 1'b1;
      end
    endcase
  end

  // Misaligned requests complete the handshake but are dropped
  assign w_accept    = sb_if.st_valid & ~r_full;
  assign w_enq       = w_accept & ~w_misaligned;
  assign w_deq       = r_nonempty & sb_if.mem_wr_ready;
  assign w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

  // Pointers, occupancy and status flags; flags are precomputed from the next count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_nonempty <= 1'b0;
      r_misalign <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
      end
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CNT_W'(DEPTH));
      r_nonempty <= (w_count_nxt != '0);
      r_misalign <= w_accept & w_misaligned;
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // Payload storage needs no reset: only slots marked valid are ever observed
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_waddr[r_wr_ptr] <= sb_if.st_addr[ADDR_W-1:2];
      r_data[r_wr_ptr]  <= w_fmt_data;
      r_strb[r_wr_ptr]  <= w_fmt_strb;
    end
  end

  // Load hazard: any held entry (including one retiring now) or an incoming aligned store
  always_comb begin
    w_ld_hit = w_enq & (sb_if.st_addr[ADDR_W-1:2] == sb_if.ld_addr[ADDR_W-1:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_waddr[i] == sb_if.ld_addr[ADDR_W-1:2])) begin
        w_ld_hit = 1'b1;
      end
    end
  end

  assign sb_if.st_ready     = ~r_full;
  assign sb_if.st_misalign  = r_misalign;
  assign sb_if.mem_wr_valid = r_nonempty;
  assign sb_if.mem_wr_addr  = {r_waddr[r_rd_ptr], 2'b00};
  assign sb_if.mem_wr_data  = r_data[r_rd_ptr];
  assign sb_if.mem_wr_strb  = r_strb[r_rd_ptr];
  assign sb_if.ld_conflict  = w_ld_hit;
  assign sb_if.sb_empty     = ~r_nonempty;

endmodule
